// File: rtl/conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// conv_frame_sequencer : raster scheduler for the 3x3 convolve datapath
// Revision 1.0
// ============================================================================
module conv_frame_sequencer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic [1:0]       stride,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             lb_wr_en,
  output logic             win_shift,
  output logic             lb_row_end,
  output logic             eng_start,
  input  logic             eng_done,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STREAM  = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [COL_W-1:0] C_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] R_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] C_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] R_TWO  = ROW_W'(2);

  state_t           state_q, state_d;
  logic [1:0]       stride_q, stride_d;
  logic [ROW_W-1:0] r_q, r_d, out_row_q, out_row_d;
  logic [COL_W-1:0] c_q, c_d, out_col_q, out_col_d;
  logic [1:0]       rph_q, rph_d, cph_q, cph_d;
  logic             last_win_q, last_win_d;
  logic             eng_start_q, eng_start_d;
  logic             frame_done_q, frame_done_d;
  logic             accept, legal, last_pix;

  // Phase counters hold (r-2)%S and (c-2)%S so window legality needs no divider.
  function automatic logic [1:0] ph_inc(input logic [1:0] ph, input logic [1:0] s);
    return (ph == s - 2'd1) ? 2'd0 : ph + 2'd1;
  endfunction

  always_comb begin
    pix_ready    = (state_q == S_STREAM);
    accept       = pix_valid & pix_ready;
    last_pix     = (r_q == R_LAST) && (c_q == C_LAST);
    legal        = (r_q >= R_TWO) && (c_q >= C_TWO) && (rph_q == 2'd0) && (cph_q == 2'd0);
    state_d      = state_q;
    stride_d     = stride_q;
    r_d          = r_q;
    c_d          = c_q;
    rph_d        = rph_q;
    cph_d        = cph_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    last_win_d   = last_win_q;
    eng_start_d  = 1'b0;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d   = S_STREAM;
          stride_d  = (stride == 2'd0) ? 2'd1 : stride;
          r_d       = '0;
          c_d       = '0;
          rph_d     = 2'd0;
          cph_d     = 2'd0;
          out_row_d = '0;
          out_col_d = '0;
        end
      end
      S_STREAM: begin
        if (accept) begin
          if (c_q == C_LAST) begin
            c_d   = '0;
            r_d   = r_q + 1'b1;
            cph_d = 2'd0;
            rph_d = (r_q < R_TWO) ? 2'd0 : ph_inc(rph_q, stride_q);
          end else begin
            c_d   = c_q + 1'b1;
            cph_d = (c_q < C_TWO) ? 2'd0 : ph_inc(cph_q, stride_q);
          end
          if (legal) begin
            state_d     = S_COMPUTE;
            eng_start_d = 1'b1;
            last_win_d  = last_pix;
            // Column 2 is always the first legal window of a row.
            if (c_q == C_TWO) begin
              out_col_d = '0;
              out_row_d = (r_q == R_TWO) ? '0 : out_row_q + 1'b1;
            end else begin
              out_col_d = out_col_q + 1'b1;
            end
          end else if (last_pix) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (eng_done && !eng_start_q) begin
          state_d      = last_win_q ? S_DONE : S_STREAM;
          frame_done_d = last_win_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stride_q     <= 2'd1;
      r_q          <= '0;
      c_q          <= '0;
      rph_q        <= 2'd0;
      cph_q        <= 2'd0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      last_win_q   <= 1'b0;
      eng_start_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      stride_q     <= stride_d;
      r_q          <= r_d;
      c_q          <= c_d;
      rph_q        <= rph_d;
      cph_q        <= cph_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      last_win_q   <= last_win_d;
      eng_start_q  <= eng_start_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lb_wr_en   = accept;
  assign win_shift  = accept;
  assign lb_row_end = accept && (c_q == C_LAST);
  assign eng_start  = eng_start_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = (state_q != S_IDLE);
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_sequencer.sv
`default_nettype none
// ============================================================================
// tb_conv_frame_sequencer : randomized bench with a frame-level reference model
// Revision 1.0
// ============================================================================
module tb_conv_frame_sequencer;
  localparam int W  = 5;
  localparam int H  = 5;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [1:0]    stride = 2'd0;
  logic          pix_valid = 1'b0;
  logic          eng_done = 1'b0;
  logic          pix_ready, lb_wr_en, win_shift, lb_row_end, eng_start, busy, frame_done;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;

  conv_frame_sequencer #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .stride(stride),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .lb_wr_en(lb_wr_en),
    .win_shift(win_shift), .lb_row_end(lb_row_end), .eng_start(eng_start),
    .eng_done(eng_done), .out_row(out_row), .out_col(out_col),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus knobs, changed only at negedge+2 so the driver never races them.
  int cfg_stride = 1;
  int eng_delay  = 1;
  bit pv_rand    = 1'b0;
  bit noise      = 1'b0;
  bit fs_req     = 1'b0;

  // Reference model: mode 0 idle, 1 streaming, 2 engine busy, 3 frame finished.
  int m_mode = 0, m_s = 1, m_r = 0, m_c = 0, m_orow = 0, m_ocol = 0;
  bit m_es = 1'b0, m_last = 1'b0;

  int n_launch = 0, n_rowend = 0, n_wr = 0, n_fdone = 0;
  int q_row[$];
  int q_col[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : driver
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      frame_start = fs_req || (noise && (m_mode == 1 || m_mode == 2) && $urandom_range(0, 5) == 0);
      stride      = (noise && !fs_req) ? 2'($urandom_range(0, 3)) : 2'(cfg_stride);
      pix_valid   = pv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      eng_done    = 1'b0;
      if (eng_start) begin
        cnt      = eng_delay;
        eng_done = noise && ($urandom_range(0, 1) == 1);
      end else if (cnt > 0) begin
        cnt--;
        eng_done = (cnt == 0);
      end else begin
        eng_done = noise && ($urandom_range(0, 3) == 0);
      end
    end
  end

  initial begin : compare
    bit legal, lastp, was_first;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_mode = 0; m_es = 1'b0; m_orow = 0; m_ocol = 0; m_r = 0; m_c = 0;
      end
      chk("pix_ready",  pix_ready,  m_mode == 1);
      chk("lb_wr_en",   lb_wr_en,   m_mode == 1 && pix_valid);
      chk("win_shift",  win_shift,  m_mode == 1 && pix_valid);
      chk("lb_row_end", lb_row_end, m_mode == 1 && pix_valid && m_c == W - 1);
      chk("eng_start",  eng_start,  m_es);
      chk("out_row",    out_row,    m_orow);
      chk("out_col",    out_col,    m_ocol);
      chk("busy",       busy,       m_mode != 0);
      chk("frame_done", frame_done, m_mode == 3);
      if (eng_start === 1'b1) begin
        n_launch++;
        q_row.push_back(int'(out_row));
        q_col.push_back(int'(out_col));
      end
      if (lb_wr_en === 1'b1)   n_wr++;
      if (lb_row_end === 1'b1) n_rowend++;
      if (frame_done === 1'b1) n_fdone++;
      if (!rst) begin
        was_first = m_es;
        m_es      = 1'b0;
        case (m_mode)
          0: if (frame_start) begin
               m_mode = 1;
               m_s    = (stride == 2'd0) ? 1 : int'(stride);
               m_r = 0; m_c = 0; m_orow = 0; m_ocol = 0;
             end
          1: if (pix_valid) begin
               legal = m_r >= 2 && m_c >= 2 && (m_r - 2) % m_s == 0 && (m_c - 2) % m_s == 0;
               lastp = (m_r == H - 1) && (m_c == W - 1);
               if (legal) begin
                 m_mode = 2; m_es = 1'b1; m_last = lastp;
                 m_orow = (m_r - 2) / m_s;
                 m_ocol = (m_c - 2) / m_s;
               end else if (lastp) begin
                 m_mode = 3;
               end
               m_c++;
               if (m_c == W) begin m_c = 0; m_r++; end
             end
          2: if (eng_done && !was_first) m_mode = m_last ? 3 : 1;
          default: m_mode = 0;
        endcase
      end
    end
  end

  task automatic start_frame(int s, int d, bit pvr, bit nz);
    @(negedge clk);
    #2;
    cfg_stride = s; eng_delay = d; pv_rand = pvr; noise = nz;
    n_launch = 0; n_rowend = 0; n_wr = 0; n_fdone = 0;
    q_row.delete();
    q_col.delete();
    fs_req = 1'b1;
    @(negedge clk);
    #2;
    fs_req = 1'b0;
  endtask

  task automatic wait_frame(string name);
    int i;
    i = 0;
    while (n_fdone == 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk({name, "_finished"}, n_fdone != 0, 1);
    repeat (3) @(negedge clk);
    #2;
    noise = 1'b0;
  endtask

  task automatic chk_coords(string name, int n, int er[9], int ec[9]);
    for (int i = 0; i < n && i < q_row.size(); i++) begin
      chk({name, "_row"}, q_row[i], er[i]);
      chk({name, "_col"}, q_col[i], ec[i]);
    end
  endtask

  initial begin : main
    int r1[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int c1[9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
    int r2[9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
    int c2[9] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    int i;

    repeat (3) @(negedge clk);
    chk("rst_busy",       busy,       0);
    chk("rst_pix_ready",  pix_ready,  0);
    chk("rst_eng_start",  eng_start,  0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_out_row",    out_row,    0);
    chk("rst_out_col",    out_col,    0);
    #2;
    rst = 1'b0;

    start_frame(1, 1, 1'b0, 1'b0);
    wait_frame("s1");
    chk("s1_launches", n_launch, 9);
    chk("s1_row_ends", n_rowend, 5);
    chk("s1_writes",   n_wr,     25);
    chk("s1_fdone",    n_fdone,  1);
    chk_coords("s1", 9, r1, c1);

    start_frame(2, 1, 1'b0, 1'b0);
    wait_frame("s2");
    chk("s2_launches", n_launch, 4);
    chk("s2_fdone",    n_fdone,  1);
    chk_coords("s2", 4, r2, c2);

    start_frame(3, 1, 1'b0, 1'b0);
    wait_frame("s3");
    chk("s3_launches", n_launch, 1);
    chk("s3_writes",   n_wr,     25);
    chk_coords("s3", 1, r2, c2);

    start_frame(1, 5, 1'b1, 1'b0);
    wait_frame("stall");
    chk("stall_launches", n_launch, 9);
    chk("stall_writes",   n_wr,     25);
    chk("stall_fdone",    n_fdone,  1);

    start_frame(0, 1, 1'b0, 1'b0);
    wait_frame("s0");
    chk("s0_launches", n_launch, 9);
    chk_coords("s0", 9, r1, c1);

    cfg_stride = 1;
    start_frame(1, 2, 1'b1, 1'b1);
    wait_frame("noise");
    chk("noise_launches", n_launch, 9);
    chk("noise_writes",   n_wr,     25);
    chk("noise_fdone",    n_fdone,  1);
    chk_coords("noise", 9, r1, c1);

    // Abort during the third window's engine run.
    start_frame(1, 5, 1'b0, 1'b0);
    i = 0;
    while (n_launch < 3 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("abort_reached", n_launch, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy",      busy,      0);
    chk("abort_pix_ready", pix_ready, 0);
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_no_fdone", n_fdone, 0);

    start_frame(1, 1, 1'b0, 1'b0);
    wait_frame("restart");
    chk("restart_launches", n_launch, 9);
    chk("restart_fdone",    n_fdone,  1);
    chk_coords("restart", 9, r1, c1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
